// File: rtl/coherence_dir_sequencer_pkg.sv
// Shared encodings for the home-node directory controller: directory
// state codes, request type codes and the sequencer FSM state encoding.
package coherence_pkg;

    // Directory / reply state codes
    localparam logic [1:0] ST_INVALID  = 2'b01;
    localparam logic [1:0] ST_SHARED   = 2'b10;
    localparam logic [1:0] ST_MODIFIED = 2'b11;

    // Request type codes
    localparam logic [1:0] REQ_WB  = 2'b00;
    localparam logic [1:0] REQ_RD  = 2'b01;
    localparam logic [1:0] REQ_WR  = 2'b10;
    localparam logic [1:0] REQ_UPG = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FETCH,
        S_INVAL,
        S_REPLY
    } seqState_t;

endpackage

// File: rtl/coherence_dir_sequencer_arbiter.sv
// Request arbiter for the directory sequencer: request vector in, one-hot
// grant plus index out. With DIR_RR_ARB_EN defined it is round-robin and
// keeps its priority pointer here; otherwise lowest index wins and it is
// purely combinational.
module dir_node_arbiter #(
    parameter int NUM_NODES = 4,
    parameter int NW        = 2
) (
`ifdef DIR_RR_ARB_EN
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grantEn,
`endif
    input  logic [NUM_NODES-1:0] reqVec,
    output logic [NUM_NODES-1:0] grantVec,
    output logic [NW-1:0]        grantIdx,
    output logic                 grantAny
);

`ifdef DIR_RR_ARB_EN
    // rrPtr is the node with highest priority (the one after the last grant)
    logic [NW-1:0] rrPtr;

    // Scan from rrPtr upward with wrap, first requester wins
    always_comb begin
        grantVec = '0;
        grantIdx = '0;
        grantAny = 1'b0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (!grantAny && reqVec[rrPtr + NW'(i)]) begin
                grantAny = 1'b1;
                grantIdx = rrPtr + NW'(i);
            end
        end
        grantVec[grantIdx] = grantAny;
    end

    // Pointer moves past the winner only when a grant is actually issued
    always_ff @(posedge clk) begin
        if (reset)
            rrPtr <= '0;
        else if (grantEn && grantAny)
            rrPtr <= grantIdx + 1'b1;
    end
`else
    // Fixed priority: scanning downward leaves the lowest requester last
    always_comb begin
        grantVec = '0;
        grantIdx = '0;
        grantAny = 1'b0;
        for (int i = NUM_NODES - 1; i >= 0; i--) begin
            if (reqVec[i]) begin
                grantAny = 1'b1;
                grantIdx = NW'(i);
            end
        end
        grantVec[grantIdx] = grantAny;
    end
`endif

endmodule

// File: rtl/coherence_dir_sequencer.sv
// Home-node directory controller. Serialises coherence requests from the
// cache nodes, looks up the block's directory entry, drives fetch and
// invalidate handshakes as needed, writes the new entry and replies.
// Optional macro DIR_RR_ARB_EN selects round-robin arbitration
// (default build: fixed priority, lowest node first).
module coherence_dir_sequencer
    import coherence_pkg::*;
#(
    parameter int NUM_NODES  = 4,
    parameter int NUM_BLOCKS = 8,
    parameter int AW         = 3,
    parameter int NW         = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_NODES-1:0]    req_valid,
    input  logic [2*NUM_NODES-1:0]  req_type,
    input  logic [AW*NUM_NODES-1:0] req_addr,
    output logic [NUM_NODES-1:0]    req_ready,
    output logic                    fetch_valid,
    output logic [NW-1:0]           fetch_node,
    output logic [AW-1:0]           fetch_addr,
    input  logic                    fetch_done,
    output logic                    inval_valid,
    output logic [NUM_NODES-1:0]    inval_mask,
    output logic [AW-1:0]           inval_addr,
    input  logic                    inval_ack,
    output logic                    reply_valid,
    output logic [NW-1:0]           reply_node,
    output logic [AW-1:0]           reply_addr,
    output logic [1:0]              reply_state,
    output logic                    busy
);

    localparam int EW = 2 + NUM_NODES;   // {state, sharers}

    seqState_t curState, nxtState;

    logic [EW-1:0]        dirMem [NUM_BLOCKS];

    // Latched transaction
    logic [NW-1:0]        curNode;
    logic [1:0]           curType;
    logic [AW-1:0]        curAddr;

    // Results captured at the end of LOOKUP
    logic [EW-1:0]        newEntry;
    logic [NW-1:0]        ownerIdx;
    logic [NUM_NODES-1:0] invMask;
    logic [1:0]           replyState;

    // LOOKUP combinational results
    logic [EW-1:0]        curEntry, lkEntry;
    logic [1:0]           curSt, lkReply;
    logic [NUM_NODES-1:0] curSh, reqBit, lkMask;
    logic [NW-1:0]        lkOwner;
    logic                 ownerIsReq, lkFetch;

    // Arbiter
    logic [NUM_NODES-1:0] grantVec;
    logic [NW-1:0]        grantIdx;
    logic                 grantAny, grantEn;

    // Grants only happen from IDLE and never in a reset cycle
    assign grantEn = (curState == S_IDLE) && !reset;

    dir_node_arbiter #(.NUM_NODES(NUM_NODES), .NW(NW)) uArb (
`ifdef DIR_RR_ARB_EN
        .clk      (clk),
        .reset    (reset),
        .grantEn  (grantEn),
`endif
        .reqVec   (req_valid),
        .grantVec (grantVec),
        .grantIdx (grantIdx),
        .grantAny (grantAny)
    );

    // Directory protocol: next entry, fetch need and invalidate set for the latched request
    always_comb begin
        curEntry   = dirMem[curAddr];
        curSt      = curEntry[EW-1 -: 2];
        curSh      = curEntry[NUM_NODES-1:0];
        reqBit     = '0;
        reqBit[curNode] = 1'b1;
        ownerIsReq = (curSt == ST_MODIFIED) && (curSh == reqBit);
        lkOwner    = '0;
        for (int i = 0; i < NUM_NODES; i++)
            if (curSh[i]) lkOwner = NW'(i);
        lkEntry    = curEntry;
        lkFetch    = 1'b0;
        lkMask     = '0;
        lkReply    = ST_INVALID;
        case (curType)
            REQ_WB: begin
                // Only the real owner retires the block; anything else is stale
                if (ownerIsReq) lkEntry = {ST_INVALID, {NUM_NODES{1'b0}}};
            end
            REQ_RD: begin
                lkReply = ST_SHARED;
                if (ownerIsReq)
                    lkEntry = {ST_MODIFIED, reqBit};
                else begin
                    lkFetch = (curSt == ST_MODIFIED);
                    lkEntry = {ST_SHARED, (curSt == ST_INVALID) ? reqBit : (curSh | reqBit)};
                end
            end
            REQ_WR, REQ_UPG: begin
                // A qualifying upgrade reduces to the SHARED write-miss path
                lkReply = ST_MODIFIED;
                lkEntry = {ST_MODIFIED, reqBit};
                if (curSt != ST_INVALID && !ownerIsReq) begin
                    lkFetch = (curSt == ST_MODIFIED);
                    lkMask  = curSh & ~reqBit;
                end
            end
            default: ;
        endcase
    end

    // Next-state and handshake outputs; data outputs read zero when not valid
    always_comb begin
        nxtState    = curState;
        req_ready   = '0;
        fetch_valid = 1'b0;
        fetch_node  = '0;
        fetch_addr  = '0;
        inval_valid = 1'b0;
        inval_mask  = '0;
        inval_addr  = '0;
        reply_valid = 1'b0;
        reply_node  = '0;
        reply_addr  = '0;
        reply_state = '0;
        busy        = (curState != S_IDLE);
        case (curState)
            S_IDLE: begin
                if (grantEn && grantAny) begin
                    req_ready = grantVec;
                    nxtState  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lkFetch)      nxtState = S_FETCH;
                else if (|lkMask) nxtState = S_INVAL;
                else              nxtState = S_REPLY;
            end
            S_FETCH: begin
                fetch_valid = 1'b1;
                fetch_node  = ownerIdx;
                fetch_addr  = curAddr;
                if (fetch_done) nxtState = (|invMask) ? S_INVAL : S_REPLY;
            end
            S_INVAL: begin
                inval_valid = 1'b1;
                inval_mask  = invMask;
                inval_addr  = curAddr;
                if (inval_ack) nxtState = S_REPLY;
            end
            S_REPLY: begin
                reply_valid = 1'b1;
                reply_node  = curNode;
                reply_addr  = curAddr;
                reply_state = replyState;
                nxtState    = S_IDLE;
            end
            default: nxtState = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) curState <= S_IDLE;
        else       curState <= nxtState;
    end

    // Latch the granted request in IDLE and the lookup results in LOOKUP
    always_ff @(posedge clk) begin
        if (reset) begin
            curNode    <= '0;
            curType    <= '0;
            curAddr    <= '0;
            newEntry   <= '0;
            ownerIdx   <= '0;
            invMask    <= '0;
            replyState <= '0;
        end else begin
            if (grantEn && grantAny) begin
                curNode <= grantIdx;
                curType <= req_type[2*grantIdx +: 2];
                curAddr <= req_addr[AW*grantIdx +: AW];
            end
            if (curState == S_LOOKUP) begin
                newEntry   <= lkEntry;
                ownerIdx   <= lkOwner;
                invMask    <= lkMask;
                replyState <= lkReply;
            end
        end
    end

    // Directory array: cleared on reset, written once per transaction in REPLY
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++)
                dirMem[i] <= {ST_INVALID, {NUM_NODES{1'b0}}};
        end else if (curState == S_REPLY) begin
            dirMem[curAddr] <= newEntry;
        end
    end

endmodule

// File: tb/tb_coherence_dir_sequencer.sv
// Bench for coherence_dir_sequencer: directed transactions, a set-based
// directory model predicting every output each cycle, and literal pins.
module tb_coherence_dir_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [7:0] req_type;
    logic [11:0] req_addr;
    logic [3:0] req_ready;
    logic       fetch_valid, fetch_done, inval_valid, inval_ack, reply_valid, busy;
    logic [1:0] fetch_node, reply_node, reply_state;
    logic [2:0] fetch_addr, inval_addr, reply_addr;
    logic [3:0] inval_mask;

    always #5 clk = ~clk;

    coherence_dir_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_ready(req_ready),
        .fetch_valid(fetch_valid), .fetch_node(fetch_node), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
        .inval_valid(inval_valid), .inval_mask(inval_mask), .inval_addr(inval_addr), .inval_ack(inval_ack),
        .reply_valid(reply_valid), .reply_node(reply_node), .reply_addr(reply_addr), .reply_state(reply_state),
        .busy(busy)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Directory model: state code and sharer set per block
    logic [1:0] mSt [8];
    logic [3:0] mSh [8];
`ifdef DIR_RR_ARB_EN
    int mPtr;
`endif

    typedef struct packed {
        logic       fetch;
        logic [1:0] owner;
        logic [3:0] mask;
        logic [1:0] rs;
        logic [1:0] nSt;
        logic [3:0] nSh;
    } res_t;

    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mSt[i] = 2'b01;
            mSh[i] = 4'b0000;
        end
`ifdef DIR_RR_ARB_EN
        mPtr = 0;
`endif
    endtask

    function automatic int modelArb(logic [3:0] v);
`ifdef DIR_RR_ARB_EN
        for (int k = 0; k < 4; k++) if (v[(mPtr + k) % 4]) return (mPtr + k) % 4;
`else
        for (int k = 0; k < 4; k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    // Protocol outcome for requester r: owner found by scanning a MODIFIED entry
    function automatic res_t model(int r, logic [1:0] t, logic [2:0] a);
        res_t o;
        logic [3:0] me;
        int own;
        bit isOwner;
        me  = 4'b0001 << r;
        own = -1;
        if (mSt[a] == 2'b11)
            for (int i = 0; i < 4; i++) if (mSh[a][i]) own = i;
        isOwner = (own == r);
        o = '0;
        o.nSt = mSt[a];
        o.nSh = mSh[a];
        case (t)
            2'b00: begin
                o.rs = 2'b01;
                if (isOwner) begin o.nSt = 2'b01; o.nSh = 4'b0000; end
            end
            2'b01: begin
                o.rs = 2'b10;
                if (isOwner) begin
                    o.nSt = 2'b11; o.nSh = me;
                end else if (own >= 0) begin
                    o.fetch = 1'b1; o.owner = own[1:0];
                    o.nSt = 2'b10; o.nSh = me | (4'b0001 << own);
                end else begin
                    o.nSt = 2'b10; o.nSh = me | mSh[a];
                end
            end
            default: begin
                o.rs = 2'b11; o.nSt = 2'b11; o.nSh = me;
                if (own >= 0 && !isOwner) begin
                    o.fetch = 1'b1; o.owner = own[1:0]; o.mask = 4'b0001 << own;
                end else if (mSt[a] == 2'b10) begin
                    o.mask = mSh[a] & ~me;
                end
            end
        endcase
        return o;
    endfunction

    // Expected outputs for the current cycle
    logic       chkOn = 1'b0;
    logic [3:0] eReady, eIm;
    logic       eFv, eIv, eRv, eBusy;
    logic [1:0] eFn, eRn, eRs;
    logic [2:0] eFa, eIa, eRa;

    task automatic clrExp();
        eReady = 0; eFv = 0; eFn = 0; eFa = 0; eIv = 0; eIm = 0; eIa = 0;
        eRv = 0; eRn = 0; eRa = 0; eRs = 0; eBusy = 0;
    endtask

    // Observed activity, used for literal pins
    int cyc = 0;
    int fetchCnt = 0, invalCnt = 0, replyCnt = 0, grantCyc = 0, replyCyc = 0, gN = 0;
    logic [1:0] lastFnode, lastRstate;
    logic [3:0] lastImask;
    logic [2:0] lastIaddr;
    logic [3:0] grantLog [64];

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the model, plus activity capture
    always @(negedge clk) begin
        if (chkOn) begin
            check("req_ready",   req_ready,   eReady);
            check("busy",        busy,        eBusy);
            check("fetch_valid", fetch_valid, eFv);
            check("fetch_node",  fetch_node,  eFn);
            check("fetch_addr",  fetch_addr,  eFa);
            check("inval_valid", inval_valid, eIv);
            check("inval_mask",  inval_mask,  eIm);
            check("inval_addr",  inval_addr,  eIa);
            check("reply_valid", reply_valid, eRv);
            check("reply_node",  reply_node,  eRn);
            check("reply_addr",  reply_addr,  eRa);
            check("reply_state", reply_state, eRs);
        end
        if (req_ready != 4'b0000 && gN < 64) begin
            grantLog[gN] = req_ready;
            gN++;
            grantCyc = cyc;
        end
        if (fetch_valid === 1'b1) begin fetchCnt++; lastFnode = fetch_node; end
        if (inval_valid === 1'b1) begin invalCnt++; lastImask = inval_mask; lastIaddr = inval_addr; end
        if (reply_valid === 1'b1) begin replyCnt++; lastRstate = reply_state; replyCyc = cyc; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int n, input logic [1:0] t, input logic [2:0] a);
        req_type[2*n +: 2] = t;
        req_addr[3*n +: 3] = a;
    endtask

    // One transaction from grant to entry write; dF/dA are cycles before done/ack
    task automatic runTxn(input int dF, input int dA, input bit keep0);
        res_t r;
        int w;
        logic [2:0] a;
        w = modelArb(req_valid);
        if (w < 0) begin
            nFail++;
            $display("FAIL runTxn: no requester to arbitrate at %0t", $time);
            return;
        end
        a = req_addr[3*w +: 3];
        r = model(w, req_type[2*w +: 2], a);
        clrExp(); eReady = 4'b0001 << w;
        step();
`ifdef DIR_RR_ARB_EN
        mPtr = (w + 1) % 4;
`endif
        if (!(keep0 && w == 0)) req_valid[w] = 1'b0;
        // LOOKUP: handshakes here must be ignored
        clrExp(); eBusy = 1; fetch_done = 1; inval_ack = 1;
        step();
        if (r.fetch)
            for (int c = 0; c <= dF; c++) begin
                clrExp(); eBusy = 1; eFv = 1; eFn = r.owner; eFa = a;
                fetch_done = (c == dF); inval_ack = 1;
                step();
            end
        if (r.mask != 4'b0000)
            for (int c = 0; c <= dA; c++) begin
                clrExp(); eBusy = 1; eIv = 1; eIm = r.mask; eIa = a;
                inval_ack = (c == dA); fetch_done = 1;
                step();
            end
        clrExp(); eBusy = 1; eRv = 1; eRn = w[1:0]; eRa = a; eRs = r.rs;
        fetch_done = 0; inval_ack = 0;
        step();
        mSt[a] = r.nSt;
        mSh[a] = r.nSh;
        clrExp();
        check("entry", dut.dirMem[a], {26'd0, mSt[a], mSh[a]});
    endtask

    int fc, ic, rc, g0;
    logic [3:0] expGrant [4];

    initial begin
        reset = 1; req_valid = 0; req_type = 0; req_addr = 0; fetch_done = 0; inval_ack = 0;
        clrExp(); modelReset();
        step(); step();
        chkOn = 1;
        step();
        reset = 0;
        for (int i = 0; i < 8; i++) check("reset entry", dut.dirMem[i], 32'h10);

        // Node 1 read miss, no fetch or invalidate, reply at T+2
        setReq(1, 2'b01, 3'd3); req_valid = 4'b0010;
        fc = fetchCnt; ic = invalCnt;
        runTxn(0, 0, 0);
        check("t1 entry literal", dut.dirMem[3], 32'h22);
        check("t1 latency", replyCyc - grantCyc, 2);
        check("t1 no fetch", fetchCnt - fc, 0);
        check("t1 no inval", invalCnt - ic, 0);
        check("t1 reply state", lastRstate, 2'b10);

        reset = 1; step(); reset = 0; modelReset();

        // Two sharers, then a write miss invalidates both
        setReq(0, 2'b01, 3'd3); setReq(2, 2'b01, 3'd3); req_valid = 4'b0101;
        runTxn(0, 0, 0);
        runTxn(0, 0, 0);
        setReq(3, 2'b10, 3'd3); req_valid = 4'b1000;
        runTxn(0, 2, 0);
        check("t2 inval mask", lastImask, 4'b0101);
        check("t2 inval addr", lastIaddr, 3'd3);
        check("t2 reply state", lastRstate, 2'b11);
        check("t2 entry literal", dut.dirMem[3], 32'h38);

        // Read miss while node 3 owns: fetch from 3
        setReq(0, 2'b01, 3'd3); req_valid = 4'b0001;
        runTxn(1, 0, 0);
        check("t3 fetch node", lastFnode, 2'd3);
        check("t3 reply state", lastRstate, 2'b10);
        check("t3 entry literal", dut.dirMem[3], 32'h29);

        // Upgrade by a sharer, then writeback by the owner, then a stale writeback
        setReq(3, 2'b11, 3'd3); req_valid = 4'b1000;
        runTxn(0, 0, 0);
        check("t4 upgrade mask", lastImask, 4'b0001);
        setReq(3, 2'b00, 3'd3); req_valid = 4'b1000;
        runTxn(0, 0, 0);
        check("t4 wb entry", dut.dirMem[3], 32'h10);
        check("t4 wb reply", lastRstate, 2'b01);
        req_valid = 4'b1000;
        runTxn(0, 0, 0);
        check("t4 stale wb entry", dut.dirMem[3], 32'h10);

        // Write miss chain on addr 5: fetch+invalidate, owner re-read, foreign upgrade
        setReq(2, 2'b10, 3'd5); req_valid = 4'b0100;
        runTxn(0, 0, 0);
        setReq(1, 2'b10, 3'd5); req_valid = 4'b0010;
        runTxn(0, 0, 0);
        check("t5 fetch node", lastFnode, 2'd2);
        check("t5 inval mask", lastImask, 4'b0100);
        setReq(1, 2'b01, 3'd5); req_valid = 4'b0010;
        fc = fetchCnt; ic = invalCnt;
        runTxn(0, 0, 0);
        check("t5 owner read no fetch", fetchCnt - fc, 0);
        check("t5 owner read no inval", invalCnt - ic, 0);
        check("t5 owner read entry", dut.dirMem[5], 32'h32);
        setReq(0, 2'b11, 3'd5); req_valid = 4'b0001;
        runTxn(2, 1, 0);
        check("t5 upgrade as write mask", lastImask, 4'b0010);

        // Reset during FETCH abandons the transaction
        setReq(2, 2'b01, 3'd5); req_valid = 4'b0100;
        clrExp(); eReady = 4'b0100;
        step();
        req_valid = 0; clrExp(); eBusy = 1;
        step();
        clrExp(); eBusy = 1; eFv = 1; eFn = 2'd0; eFa = 3'd5;
        reset = 1; rc = replyCnt;
        step();
        reset = 0; clrExp(); modelReset();
        step(); step();
        check("t6 no reply", replyCnt - rc, 0);
        for (int i = 0; i < 8; i++) check("t6 entry invalid", dut.dirMem[i], 32'h10);

        // Arbitration: all four request, node 0 keeps re-requesting
        setReq(0, 2'b01, 3'd4); setReq(1, 2'b01, 3'd1); setReq(2, 2'b01, 3'd2); setReq(3, 2'b01, 3'd6);
        req_valid = 4'b1111;
        g0 = gN;
        for (int k = 0; k < 4; k++) runTxn(0, 0, 1);
        req_valid = 0;
        clrExp();
        step(); step();
`ifdef DIR_RR_ARB_EN
        expGrant[0] = 4'b0001; expGrant[1] = 4'b0010; expGrant[2] = 4'b0100; expGrant[3] = 4'b1000;
`else
        expGrant[0] = 4'b0001; expGrant[1] = 4'b0001; expGrant[2] = 4'b0001; expGrant[3] = 4'b0001;
`endif
        check("arb grant count", gN - g0, 4);
        for (int k = 0; k < 4; k++) check("arb grant order", grantLog[(g0 + k) % 64], expGrant[k]);

        chkOn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/coherence_dir_sequencer.md
# coherence_dir_sequencer

Home-node directory controller for the directory-based coherence system. It accepts coherence requests from NUM_NODES cache controllers and arbitrates them onto one directory, one transaction at a time. For each transaction it reads the per-block directory entry, fetches from the owner and invalidates sharers as needed, updates the entry and replies to the requester. It owns the directory state and sharer vectors that the per-cache CPU and bus state machines act on.

## Interface
- NUM_NODES, 4, number of cache nodes; also the sharer-vector width.
- NUM_BLOCKS, 8, number of directory entries.
- AW, 3, block address width, equal to log2(NUM_BLOCKS).
- NW, 2, node index width, equal to log2(NUM_NODES).
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_NODES  per-node request; held high until granted.
- req_type  in  2*NUM_NODES  per-node type: 00 writeback, 01 read miss, 10 write miss, 11 upgrade.
- req_addr  in  AW*NUM_NODES  per-node block address.
- req_ready  out  NUM_NODES  one-hot grant pulse, one cycle long.
- fetch_valid  out  1  fetch/write-back demand to the owner; held until fetch_done.
- fetch_node  out  NW  owner index.
- fetch_addr  out  AW  block address to fetch.
- fetch_done  in  1  owner data written back.
- inval_valid  out  1  invalidate the nodes in inval_mask; held until inval_ack.
- inval_mask  out  NUM_NODES  nodes to invalidate.
- inval_addr  out  AW  block address to invalidate.
- inval_ack  in  1  all invalidates in the mask are complete.
- reply_valid  out  1  one-cycle reply pulse.
- reply_node  out  NW  requester index.
- reply_addr  out  AW  block address of the reply.
- reply_state  out  2  state granted to the requester: 10 SHARED, 11 MODIFIED, 01 INVALID (writeback acknowledge).
- busy  out  1  high in any state other than IDLE.

## Operation
- State codes: INVALID 2'b01 (uncached), SHARED 2'b10, MODIFIED 2'b11.
- Directory entry layout: {state[1:0], sharers[NUM_NODES-1:0]}. In MODIFIED, sharers is the one-hot owner.
- Main FSM states: IDLE, LOOKUP, FETCH, INVAL, REPLY.
- IDLE: if any req_valid is set, grant one node and pulse req_ready. Latch node, type and address, then go to LOOKUP.
- LOOKUP (1 cycle): read the entry and compute the next entry, the fetch need and the invalidate mask. Then go to FETCH if a fetch is needed, otherwise INVAL if the mask is non-zero, otherwise REPLY.
- FETCH: hold fetch_valid until fetch_done. Then go to INVAL if the mask is non-zero, otherwise REPLY.
- INVAL: hold inval_valid until inval_ack, then go to REPLY.
- REPLY (1 cycle): pulse reply_valid, write the entry, return to IDLE.
- Read miss (R = requester):
  - INVALID → SHARED, sharers = {R}.
  - SHARED → sharers |= {R}.
  - MODIFIED with owner ≠ R → fetch from the owner, then SHARED with sharers = owner | R.
  - reply_state is SHARED.
- Write miss:
  - INVALID → MODIFIED, owner R.
  - SHARED → invalidate sharers & ~R, then MODIFIED, owner R.
  - MODIFIED with owner ≠ R → fetch, then invalidate the owner, then owner R.
  - reply_state is MODIFIED.
- Upgrade: if the entry is SHARED and R is a sharer, invalidate the other sharers and go to MODIFIED. Any other upgrade is processed exactly as a write miss.
- Writeback:
  - Entry MODIFIED and owner == R → INVALID, sharers = 0.
  - Otherwise the entry is unchanged (stale writeback).
  - Both cases reply with reply_state INVALID.
- MODIFIED entry with owner == R on a read miss or write miss: no fetch, no invalidate; the entry becomes MODIFIED with owner R.

## Timing
- Reset values:
  - All outputs 0.
  - All entries INVALID with sharers 0.
  - Round-robin pointer 0.
  - FSM in IDLE.
- A reset mid-transaction abandons the transaction; nothing is replied.
- Minimum latency, with no fetch and no invalidate: grant in cycle T, reply_valid in T+2.
- fetch_valid rises in the cycle after LOOKUP. A fetch_done present in the first FETCH cycle is accepted, so FETCH takes one cycle. The same rule applies to inval_ack in INVAL.
- The next grant can occur in the cycle after REPLY. Back-to-back transactions are therefore 3 cycles apart at best.
- fetch_done and inval_ack are ignored outside FETCH and INVAL respectively.
- req_valid of non-granted nodes may stay high indefinitely. They are not granted while busy.

## Configuration
- DIR_RR_ARB_EN defined: round-robin arbitration. The node after the last-granted node has highest priority, wrapping from NUM_NODES-1 to 0. The pointer updates only on a grant.
- DIR_RR_ARB_EN undefined: fixed priority, lowest node index wins. No pointer register exists.

## Structure
- coherence_pkg holds:
  - the state codes;
  - the req_type codes;
  - the FSM state encoding.
- Sub-module dir_node_arbiter: request vector in, one-hot grant plus index out. The round-robin pointer lives inside it.
- The directory array and the FSM stay in the top module.

## Test plan
- Node 1 read-misses addr 3 after reset → reply node 1, SHARED, at T+2; entry is {SHARED, 4'b0010}; no fetch_valid or inval_valid.
- Nodes 0 and 2 read-miss addr 3, then node 3 write-misses addr 3 → inval_mask 4'b0101, addr 3; after the ack, reply MODIFIED; entry is {MODIFIED, 4'b1000}.
- Node 0 read-misses addr 3 while node 3 owns it → fetch_node 3; after fetch_done, reply SHARED; entry is {SHARED, 4'b1001}.
- Node 3 writes back addr 3 while it is the owner → entry is {INVALID, 0} and reply_state is INVALID. A second writeback from node 3 leaves the entry unchanged.
- All four nodes hold req_valid with DIR_RR_ARB_EN defined → grant order 0, 1, 2, 3. Without the macro, node 0 wins every arbitration while it requests.
- Assert reset during FETCH → the next cycle has all outputs 0, all entries INVALID, and no reply.
